// File: rtl/uart_tx_sched.sv
// uart_tx_sched: shares one UART TX serializer between a buffered bus source
// (source 0, DEPTH-entry FIFO) and an unbuffered panel source (source 1,
// 1-entry holding register). One byte is launched at a time with a
// tx_start / tx_busy handshake. The module also reports a sticky overrun (ovr)
// and a sticky handshake timeout (tmo).
//
// Optional feature: define UART_SCHED_RR_EN for round-robin arbitration when
// both sources are pending. Without it, source 0 has fixed priority.

module uart_tx_sched #(
  parameter int DEPTH  = 4,
  parameter int TO_CYC = 16
) (
  input  logic                   pClk,
  input  logic                   pReset,
  input  logic                   s0_valid,
  input  logic [7:0]             s0_data,
  output logic                   s0_ready,
  input  logic                   s1_valid,
  input  logic [7:0]             s1_data,
  output logic                   s1_ready,
  input  logic                   tx_busy,
  output logic                   tx_start,
  output logic [7:0]             tx_data,
  output logic                   grant_id,
  output logic [$clog2(DEPTH):0] fifo_count,
  output logic                   ovr,
  output logic                   tmo,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TO_CYC + 1);
  localparam logic [AW:0]   FULL_CNT = (AW + 1)'(DEPTH);
  localparam logic [TW-1:0] LAST_CNT = TW'(TO_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE
  } stateT;

  stateT         state;
  logic [7:0]    fifoMem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic          holdFull;
  logic [7:0]    holdData;
  logic [TW-1:0] waitCnt;

  logic pend0;
  logic pend1;
  logic launchOk;
  logic pick0;
  logic push0;
  logic push1;
  logic pop0;
  logic pop1;
  logic ovrEvent;
  logic tmoEvent;

  // Ready flags depend only on registered occupancy, never on the valids.
  assign s0_ready = (fifo_count < FULL_CNT);
  assign s1_ready = !holdFull;

  assign push0    = s0_valid && s0_ready;
  assign push1    = s1_valid && (!holdFull || pop1);
  assign ovrEvent = s1_valid && holdFull && !pop1;
  assign tmoEvent = (state == WAIT_BUSY) && !tx_busy && (waitCnt == LAST_CNT);

  // Arbitration: decide whether a launch happens this cycle and from which source.
  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    pend0    = (fifo_count != '0);
    pend1    = holdFull;
    launchOk = (state == IDLE) && !tx_busy && (pend0 || pend1);
`ifdef UART_SCHED_RR_EN
    // On a tie the grant goes to the source opposite the last one launched.
    pick0    = (pend0 && pend1) ? grant_id : pend0;
`else
    // Source 0 always wins; source 1 only runs while the FIFO is empty.
    pick0    = pend0;
`endif
    pop0     = launchOk && pick0;
    pop1     = launchOk && !pick0;
  end

  // Source-0 FIFO storage.
  always_ff @(posedge pClk) begin
    // NOTE: storage is deliberately not reset; occupancy is tracked by
    // fifo_count, so stale contents are never read.
    if (push0) begin
      fifoMem[wrPtr] <= s0_data;
    end
  end

  // Source-0 FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      wrPtr      <= '0;
      rdPtr      <= '0;
      fifo_count <= '0;
    end else begin
      if (push0) wrPtr <= wrPtr + 1'b1;
      if (pop0)  rdPtr <= rdPtr + 1'b1;
      case ({push0, pop0})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Source-1 holding register and sticky overrun flag (a set beats err_clr).
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      holdFull <= 1'b0;
      holdData <= '0;
      ovr      <= 1'b0;
    end else begin
      if (push1) begin
        holdFull <= 1'b1;
        holdData <= s1_data;
      end else if (pop1) begin
        holdFull <= 1'b0;
      end
      if (ovrEvent) begin
        ovr <= 1'b1;
      end else if (err_clr) begin
        ovr <= 1'b0;
      end
    end
  end

  // Launch FSM with registered tx_start/tx_data/grant_id and sticky timeout.
  always_ff @(posedge pClk or negedge pReset) begin
    if (!pReset) begin
      state    <= IDLE;
      tx_start <= 1'b0;
      tx_data  <= '0;
      grant_id <= 1'b1;
      waitCnt  <= '0;
      tmo      <= 1'b0;
    end else begin
      // NOTE: tx_start defaults low each cycle so it is a single-cycle pulse.
      tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (launchOk) begin
            tx_data  <= pick0 ? fifoMem[rdPtr] : holdData;
            grant_id <= !pick0;
            tx_start <= 1'b1;
            state    <= LAUNCH;
          end
        end
        LAUNCH: begin
          waitCnt <= '0;
          state   <= WAIT_BUSY;
        end
        WAIT_BUSY: begin
          if (tx_busy) begin
            state <= WAIT_DONE;
          end else if (waitCnt == LAST_CNT) begin
            state <= IDLE;
          end else begin
            waitCnt <= waitCnt + 1'b1;
          end
        end
        WAIT_DONE: begin
          if (!tx_busy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
      if (tmoEvent) begin
        tmo <= 1'b1;
      end else if (err_clr) begin
        tmo <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_tx_sched.sv
// Testbench for uart_tx_sched: directed stimulus, expected launches queued in a
// scoreboard, and a monitor that compares every tx_start against that queue.
// A small serializer model raises tx_busy one cycle after tx_start for 10 cycles.

module tb_uart_tx_sched;

  localparam int DEPTH  = 4;
  localparam int TO_CYC = 16;

  logic       pClk;
  logic       pReset;
  logic       s0_valid;
  logic [7:0] s0_data;
  logic       s0_ready;
  logic       s1_valid;
  logic [7:0] s1_data;
  logic       s1_ready;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       grant_id;
  logic [2:0] fifo_count;
  logic       ovr;
  logic       tmo;
  logic       err_clr;

  logic forceBusy;
  logic serBusy;
  logic serEn;

  int checks    = 0;
  int errors    = 0;
  int launchCnt = 0;

  logic [8:0] expQ [$];
  logic [8:0] monExp;

  assign tx_busy = forceBusy | serBusy;

  uart_tx_sched #(.DEPTH(DEPTH), .TO_CYC(TO_CYC)) dut (
    .pClk       (pClk),
    .pReset     (pReset),
    .s0_valid   (s0_valid),
    .s0_data    (s0_data),
    .s0_ready   (s0_ready),
    .s1_valid   (s1_valid),
    .s1_data    (s1_data),
    .s1_ready   (s1_ready),
    .tx_busy    (tx_busy),
    .tx_start   (tx_start),
    .tx_data    (tx_data),
    .grant_id   (grant_id),
    .fifo_count (fifo_count),
    .ovr        (ovr),
    .tmo        (tmo),
    .err_clr    (err_clr)
  );

  initial pClk = 1'b0;
  always #5 pClk = ~pClk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every launch must match the head of the expected queue.
  initial begin
    forever begin
      @(negedge pClk);
      if (pReset && tx_start === 1'b1) begin
        launchCnt++;
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_launch: got tx_data 0x%0h grant %0d, expected no launch", tx_data, grant_id);
        end else begin
          monExp = expQ.pop_front();
          check("launch_tx_data", 32'(tx_data), 32'(monExp[7:0]));
          check("launch_grant_id", 32'(grant_id), 32'(monExp[8]));
        end
      end
    end
  end

  // Serializer model: busy one cycle after tx_start, for 10 cycles.
  initial begin
    serBusy = 1'b0;
    forever begin
      @(posedge pClk);
      #1;
      if (serEn && tx_start) begin
        @(posedge pClk);
        #1 serBusy = 1'b1;
        repeat (10) @(posedge pClk);
        #1 serBusy = 1'b0;
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic push0(input logic [7:0] d);
    @(negedge pClk);
    s0_valid = 1'b1;
    s0_data  = d;
    @(negedge pClk);
    s0_valid = 1'b0;
  endtask

  task automatic push0Wait(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge pClk);
    while (!s0_ready && n < 300) begin
      @(negedge pClk);
      n++;
    end
    check("s0_ready_wait", 32'(s0_ready), 32'd1);
    s0_valid = 1'b1;
    s0_data  = d;
    @(negedge pClk);
    s0_valid = 1'b0;
  endtask

  task automatic push1(input logic [7:0] d);
    @(negedge pClk);
    s1_valid = 1'b1;
    s1_data  = d;
    @(negedge pClk);
    s1_valid = 1'b0;
  endtask

  task automatic pulseErrClr();
    @(negedge pClk);
    err_clr = 1'b1;
    @(negedge pClk);
    err_clr = 1'b0;
  endtask

  // Wait until all expected launches are seen and the link is quiet.
  task automatic drain();
    int quiet;
    int n;
    quiet = 0;
    n     = 0;
    while ((expQ.size() != 0 || quiet < 4) && n < 1000) begin
      @(negedge pClk);
      n++;
      if (!tx_busy && !tx_start) quiet++;
      else quiet = 0;
    end
    check("drain_pending", 32'(expQ.size()), 32'd0);
  endtask

  task automatic waitStart(input string name);
    int n;
    n = 0;
    do begin
      @(negedge pClk);
      n++;
    end while (!tx_start && n < 60);
    check(name, 32'(tx_start), 32'd1);
  endtask

  task automatic checkResetValues(input string tag);
    check({tag, "_tx_start"},   32'(tx_start),   32'd0);
    check({tag, "_tx_data"},    32'(tx_data),    32'd0);
    check({tag, "_grant_id"},   32'(grant_id),   32'd1);
    check({tag, "_fifo_count"}, 32'(fifo_count), 32'd0);
    check({tag, "_s0_ready"},   32'(s0_ready),   32'd1);
    check({tag, "_s1_ready"},   32'(s1_ready),   32'd1);
    check({tag, "_ovr"},        32'(ovr),        32'd0);
    check({tag, "_tmo"},        32'(tmo),        32'd0);
  endtask

  task automatic resetDut();
    @(negedge pClk);
    pReset = 1'b0;
    repeat (2) @(negedge pClk);
    pReset = 1'b1;
  endtask

  // Directed stimulus.
  initial begin
    int launchSnap;
    pReset    = 1'b0;
    s0_valid  = 1'b0;
    s0_data   = '0;
    s1_valid  = 1'b0;
    s1_data   = '0;
    err_clr   = 1'b0;
    forceBusy = 1'b0;
    serEn     = 1'b1;

    repeat (3) @(negedge pClk);
    checkResetValues("reset");
    pReset = 1'b1;

    // Single byte: launch visible in the cycle after edge k+1.
    expQ.push_back({1'b0, 8'h41});
    push0(8'h41);
    check("single_count_k", 32'(fifo_count), 32'd1);
    check("single_no_start_k", 32'(tx_start), 32'd0);
    @(negedge pClk);
    check("single_start_k1", 32'(tx_start), 32'd1);
    check("single_data", 32'(tx_data), 32'h41);
    drain();
    check("single_launch_count", 32'(launchCnt), 32'd1);

    // FIFO full: fifth byte dropped.
    forceBusy = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      expQ.push_back({1'b0, 8'(i)});
      push0(8'(i));
    end
    check("full_count", 32'(fifo_count), 32'd4);
    check("full_s0_ready", 32'(s0_ready), 32'd0);
    push0(8'h05);
    check("full_drop_count", 32'(fifo_count), 32'd4);
    forceBusy = 1'b0;
    drain();
    check("full_launch_count", 32'(launchCnt), 32'd5);

    // Pointer wrap with the serializer running; order preserved.
    for (int i = 0; i < 6; i++) begin
      expQ.push_back({1'b0, 8'(8'h61 + i)});
      push0Wait(8'(8'h61 + i));
    end
    drain();
    check("wrap_count_empty", 32'(fifo_count), 32'd0);
    check("wrap_launch_count", 32'(launchCnt), 32'd11);

    // Tie between sources, fresh from reset.
    resetDut();
    check("tie_grant_reset", 32'(grant_id), 32'd1);
    forceBusy = 1'b1;
    push0(8'h10);
    push0(8'h11);
    push1(8'hA5);
    check("tie_count", 32'(fifo_count), 32'd2);
    check("tie_s1_ready", 32'(s1_ready), 32'd0);
`ifdef UART_SCHED_RR_EN
    expQ.push_back({1'b0, 8'h10});
    expQ.push_back({1'b1, 8'hA5});
    expQ.push_back({1'b0, 8'h11});
`else
    expQ.push_back({1'b0, 8'h10});
    expQ.push_back({1'b0, 8'h11});
    expQ.push_back({1'b1, 8'hA5});
`endif
    forceBusy = 1'b0;
    drain();

    // Overrun: second panel byte dropped, first one kept.
    forceBusy = 1'b1;
    push1(8'h3C);
    check("ovr_clear_after_first", 32'(ovr), 32'd0);
    push1(8'hC3);
    check("ovr_set", 32'(ovr), 32'd1);
    check("ovr_s1_ready", 32'(s1_ready), 32'd0);
    pulseErrClr();
    check("ovr_cleared", 32'(ovr), 32'd0);
    expQ.push_back({1'b1, 8'h3C});
    forceBusy = 1'b0;
    drain();

    // Timeout: serializer never answers the first launch.
    serEn     = 1'b0;
    forceBusy = 1'b1;
    push0(8'h21);
    push0(8'h22);
    expQ.push_back({1'b0, 8'h21});
    expQ.push_back({1'b0, 8'h22});
    forceBusy = 1'b0;
    waitStart("tmo_first_launch");
    repeat (TO_CYC) @(negedge pClk);
    check("tmo_not_early", 32'(tmo), 32'd0);
    @(negedge pClk);
    check("tmo_set", 32'(tmo), 32'd1);
    check("tmo_no_start_yet", 32'(tx_start), 32'd0);
    serEn = 1'b1;
    @(negedge pClk);
    check("tmo_next_launch", 32'(tx_start), 32'd1);
    drain();
    check("tmo_sticky", 32'(tmo), 32'd1);
    pulseErrClr();
    check("tmo_cleared", 32'(tmo), 32'd0);

    // Asynchronous reset during WAIT_DONE with three bytes queued.
    forceBusy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push0(8'(8'h31 + i));
    end
    expQ.push_back({1'b0, 8'h31});
    forceBusy = 1'b0;
    waitStart("rst_first_launch");
    repeat (4) @(negedge pClk);
    check("rst_queued", 32'(fifo_count), 32'd3);
    #2;
    pReset = 1'b0;
    #1;
    checkResetValues("async_reset");
    @(negedge pClk);
    pReset = 1'b1;
    launchSnap = launchCnt;
    repeat (30) @(negedge pClk);
    check("rst_no_launch_after", 32'(launchCnt), 32'(launchSnap));
    check("rst_queue_empty", 32'(expQ.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_sched.md
# uart_tx_sched

Transmit scheduler that shares one UART TX serializer between two byte sources: a buffered bus-side source (APB register writes) and an unbuffered panel source (switch byte captured on a button edge). It queues, arbitrates and launches one byte at a time with a start/busy handshake to the serializer. It also reports overrun and handshake-timeout status. It sits between the UART register block / edge detector and the TX serializer in the UART register top level.

## Interface
- DEPTH, 4, source-0 FIFO depth; power of 2, minimum 2
- TO_CYC, 16, cycles to wait for serializer busy after a launch before timeout
- pClk  in  1  system clock, all logic on rising edge
- pReset  in  1  asynchronous, active-low reset
- s0_valid  in  1  source-0 (bus) byte valid
- s0_data  in  8  source-0 byte
- s0_ready  out  1  FIFO not full; push on s0_valid && s0_ready
- s1_valid  in  1  source-1 (panel) byte valid, typically a 1-cycle button-edge pulse
- s1_data  in  8  source-1 byte (switch value)
- s1_ready  out  1  source-1 holding register empty
- tx_busy  in  1  serializer busy
- tx_start  out  1  1-cycle launch pulse to serializer
- tx_data  out  8  byte to send; stable from tx_start until the next launch
- grant_id  out  1  source of the most recent launch
- fifo_count  out  $clog2(DEPTH)+1  source-0 FIFO occupancy
- ovr  out  1  sticky: s1_valid arrived while the holding register was full
- tmo  out  1  sticky: serializer never raised tx_busy within TO_CYC cycles
- err_clr  in  1  clears ovr and tmo

## Operation
- Reset values: tx_start=0, tx_data=0, grant_id=1, fifo_count=0, s0_ready=1, s1_ready=1, ovr=0, tmo=0. FIFO and holding register are emptied. FSM enters IDLE. Reset mid-transfer abandons the byte; the serializer is not notified.
- Source 0: DEPTH-entry circular FIFO with wrapping read/write pointers. Pushes are ignored while full (s0_ready=0). A push and a pop in the same cycle leave the count unchanged.
- Source 1: 1-entry holding register. s1_valid while full drops the byte and sets ovr. s1_valid in the same cycle the holding register is popped is accepted.
- If err_clr and a new error event occur in the same cycle, the set wins.
- FSM states:
  - IDLE: if tx_busy=0 and any source is pending, select a source, pop its byte into tx_data, update grant_id, go to LAUNCH. Otherwise stay.
  - LAUNCH: tx_start=1 for exactly this cycle, then go to WAIT_BUSY.
  - WAIT_BUSY: if tx_busy=1, go to WAIT_DONE. Otherwise count; after TO_CYC cycles, set tmo and go to IDLE.
  - WAIT_DONE: when tx_busy=0, go to IDLE.
- Arbitration with both sources pending follows Configuration. With one source pending, that source is granted.

## Timing
- A source-0 push at edge k appears in fifo_count after edge k. With the FSM in IDLE and tx_busy=0, IDLE selects at edge k+1 and tx_start is high in the cycle following edge k+1. Source 1 has the same 2-edge latency.
- s0_ready and s1_ready are registered-state functions: s0_ready=(fifo_count<DEPTH), s1_ready=!hold_full. They are not combinational on the valid inputs.
- Minimum spacing between consecutive tx_start pulses is 4 cycles (LAUNCH, ≥1 WAIT_BUSY, ≥1 WAIT_DONE, IDLE).
- tx_busy already high when the FSM is in IDLE blocks launches. Pending bytes wait.

## Configuration
- UART_SCHED_RR_EN defined: round-robin arbitration. When both sources are pending, the grant goes to the source opposite grant_id. Since grant_id resets to 1, source 0 wins the first tie.
- UART_SCHED_RR_EN undefined: fixed priority. Source 0 always wins ties; source 1 is served only while the FIFO is empty. grant_id still reports the launched source.

## Test plan
- Single byte: push s0_data=0x41, tx_busy responds 1 cycle after tx_start for 10 cycles → exactly one tx_start, 2 edges after the push, with tx_data=0x41 and grant_id=0.
- FIFO full/wrap: with tx_busy held high, push 0x01..0x05 → fifo_count=4, s0_ready=0, and 0x05 is dropped. Release tx_busy and emulate the serializer → launches 0x01..0x04 in order. Then push 6 more bytes to exercise pointer wrap; order is preserved.
- Tie, RR_EN defined: preload FIFO with 0x10,0x11, set holding=0xA5, tx_busy low → launch order 0x10, 0xA5, 0x11. Same stimulus without RR_EN → order 0x10, 0x11, 0xA5.
- Overrun: two s1_valid pulses (0x3C, then 0xC3) while tx_busy is high → ovr=1 and the holding register keeps 0x3C. err_clr → ovr=0.
- Timeout: hold tx_busy=0 after a launch → tmo=1 after TO_CYC=16 cycles in WAIT_BUSY, FSM returns to IDLE, and the next pending byte launches.
- Reset mid-operation: deassert pReset during WAIT_DONE with 3 bytes queued → all outputs at reset values immediately (asynchronous) and fifo_count=0.
